branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Back-end scheduler for branch resolution in the dual-issue execute stage. It collects resolved-branch results from both branch ALU pipes, selects the oldest mispredict, and issues a single registered front-end redirect. It then squashes wrong-path results for a fixed window and serialises predictor updates through a small FIFO onto the predictor's single update port.

## Interface
Parameters:
- FIFO_DEPTH, 4, predictor-update queue entries; power of two, ≥ 2
- SQUASH_CYC, 2, cycles of result squash after any redirect/external flush; ≥ 1

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- ex0_valid  in  1  pipe 0 (older slot) carries a resolved instruction this cycle
- ex0_update_en  in  1  pipe 0 instruction is a branch needing predictor update
- ex0_flush  in  1  pipe 0 branch mispredicted (direction or target)
- ex0_taken  in  1  pipe 0 actual direction
- ex0_target  in  32  pipe 0 actual next PC (target if taken, pc+4 otherwise)
- ex0_pc  in  32  pipe 0 branch PC
- ex1_valid, ex1_update_en, ex1_flush, ex1_taken, ex1_target, ex1_pc  in  1/1/1/1/32/32  same for pipe 1 (younger slot)
- ext_flush  in  1  exception/ertn flush from commit
- redirect_valid  out  1  one-cycle front-end redirect pulse
- redirect_pc  out  32  redirect fetch address
- squash  out  1  kill in-flight execute results
- upd_valid  out  1  predictor update available
- upd_ready  in  1  predictor accepts update
- upd_pc, upd_target  out  32  update PC and actual next PC
- upd_taken  out  1  update direction
- drop_cnt  out  8  saturating count of dropped updates

## Operation
- Effective inputs: exN_* qualified by exN_valid and by !squash (state IDLE). Squashed inputs have no effect.
- Pipe 0 is always older. If effective ex0_flush: redirect to ex0_target; pipe 1 entirely discarded (no redirect, no update).
- Else if effective ex1_flush: redirect to ex1_target; pipe 0 update still enqueued.
- ext_flush has priority over both pipes in the same cycle. It enters SQUASH, generates no redirect, and enqueues nothing from that cycle. The FIFO contents are kept, since those updates come from committed-path branches.
- FSM: IDLE → SQUASH on a branch redirect or ext_flush, loading a counter with SQUASH_CYC-1. SQUASH decrements each cycle and returns to IDLE when it reaches 0 and ext_flush is low. ext_flush during SQUASH reloads the counter. Branch flushes in SQUASH are ignored.
- Update FIFO: each cycle push 0–2 entries in age order (pipe 0 first) for effective exN_update_en. Free slots = DEPTH − count + (pop this cycle). If incoming exceeds free slots, drop the youngest first and increment drop_cnt by the number dropped, saturating at 255.
- Pop when upd_valid && upd_ready. Head entry drives upd_* combinationally from storage; upd_valid = count ≠ 0.
- Count width log2(DEPTH)+1; read/write pointers log2(DEPTH) bits, wrap naturally.

## Timing
- Reset (rst_n low at edge): redirect_valid 0, redirect_pc 0, squash 0, FSM IDLE, count 0, pointers 0, upd_valid 0, drop_cnt 0. Reset overrides all inputs in that cycle.
- Redirect latency 1: flush at cycle N → redirect_valid=1, redirect_pc valid at N+1, exactly one cycle.
- squash=1 for cycles N+1 … N+SQUASH_CYC, so it is high in the same cycle as redirect_valid.
- Update latency: entry pushed at N is visible on upd_* at N+1 at the earliest. Throughput is 1 pop/cycle.
- Full FIFO with simultaneous pop: one incoming entry is accepted, not dropped.
- Empty FIFO with simultaneous push: no bypass; upd_valid rises the next cycle.

## Structure
- Shared package/header: redirect-cause encoding (NONE/BR0/BR1/EXT) and the update-entry struct {pc, target, taken}.
- One natural sub-module: bp_update_fifo, a 2-write/1-read FIFO with a partial-accept count output. The FSM and priority logic stay in the top module.

## Test plan
- Reset mid-SQUASH with FIFO holding 3 entries → next cycle: all outputs 0, upd_valid 0, squash 0.
- ex0_flush=1, target 0x1c000100, with ex1_flush=1 and update_en=1 → redirect_pc=0x1c000100 at N+1; only the pipe 0 entry is enqueued; squash high for 2 cycles.
- ex0 update, not flushing, with ex1_flush=1, target 0x1c000200 → redirect 0x1c000200; two FIFO entries, pipe 0 first.
- ext_flush together with ex0_flush → no redirect_valid; squash asserted; FIFO unchanged. A second ext_flush during SQUASH extends the window by a full SQUASH_CYC.
- FIFO full, upd_ready=0, two updates pushed → both dropped, drop_cnt +2. Same with upd_ready=1 → pipe 0 accepted, pipe 1 dropped, drop_cnt +1.
- 300 overflow drops → drop_cnt saturates at 255.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the branch redirect controller: redirect causes, the
// predictor-update entry layout and the squash FSM states.
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_BR0  = 2'd1,
        CAUSE_BR1  = 2'd2,
        CAUSE_EXT  = 2'd3
    } redirect_cause_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SQUASH = 1'b1
    } squash_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } upd_entry_t;

    localparam int ENTRY_W = $bits(upd_entry_t);

    function automatic upd_entry_t make_entry(input logic [31:0] pc,
                                              input logic [31:0] target,
                                              input logic        taken);
        upd_entry_t e;
        e.pc     = pc;
        e.target = target;
        e.taken  = taken;
        return e;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_fifo.sv
// bp_update_fifo: 2-write/1-read queue of predictor updates. Writes are taken
// in age order; whatever does not fit is reported on o_drop.
module bp_update_fifo
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push0,
    input  logic [ENTRY_W-1:0] i_data0,
    input  logic               i_push1,
    input  logic [ENTRY_W-1:0] i_data1,
    input  logic               i_pop_ready,
    output logic               o_valid,
    output logic [ENTRY_W-1:0] o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [1:0]         o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;

    logic               w_pop;
    logic [1:0]         w_n_in;
    logic [1:0]         w_n_acc;
    logic [CW:0]        w_free;
    logic [ENTRY_W-1:0] w_wr0;
    logic [ENTRY_W-1:0] w_wr1;

    always_comb begin
        w_pop  = (r_count != '0) && i_pop_ready;
        w_n_in = {1'b0, i_push0} + {1'b0, i_push1};
        // A same-cycle pop frees a slot for the incoming entries.
        w_free = (CW+1)'(DEPTH) - {1'b0, r_count} + {{CW{1'b0}}, w_pop};
        if ({{(CW-1){1'b0}}, w_n_in} <= w_free) begin
            w_n_acc = w_n_in;
        end else begin
            w_n_acc = w_free[1:0];
        end
        // Compact so the oldest accepted entry always lands at the write pointer.
        w_wr0  = i_push0 ? i_data0 : i_data1;
        w_wr1  = i_data1;
        o_drop = w_n_in - w_n_acc;
    end

    always_ff @(posedge i_clk) begin
        if (w_n_acc != 2'd0) begin
            r_mem[r_wptr] <= w_wr0;
        end
        if (w_n_acc == 2'd2) begin
            r_mem[r_wptr + AW'(1)] <= w_wr1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_n_acc);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + CW'(w_n_acc) - CW'(w_pop);
        end
    end

    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: picks the oldest mispredict across both pipes,
// issues one registered redirect, squashes wrong-path results and queues updates.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SQUASH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex0_valid,
    input  logic        ex0_update_en,
    input  logic        ex0_flush,
    input  logic        ex0_taken,
    input  logic [31:0] ex0_target,
    input  logic [31:0] ex0_pc,
    input  logic        ex1_valid,
    input  logic        ex1_update_en,
    input  logic        ex1_flush,
    input  logic        ex1_taken,
    input  logic [31:0] ex1_target,
    input  logic [31:0] ex1_pc,
    input  logic        ext_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        squash,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic        upd_taken,
    output logic [7:0]  drop_cnt,
    output logic        dbg_state
);

    // Update port handshake: an entry transfers on a cycle where upd_valid and
    // upd_ready are both high; upd_* stay stable while upd_valid && !upd_ready.

    localparam int SQ_W = $clog2(SQUASH_CYC + 1);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    squash_state_e      r_state, w_state_nxt;
    logic [SQ_W-1:0]    r_sq_cnt, w_sq_cnt_nxt;
    logic               r_redirect_valid;
    logic [31:0]        r_redirect_pc;
    logic [7:0]         r_drop_cnt;

    redirect_cause_e    w_cause;
    logic               w_idle;
    logic               w_eff0;
    logic               w_eff1;
    logic               w_br0;
    logic               w_br1;
    logic               w_push0;
    logic               w_push1;
    logic [1:0]         w_fifo_drop;
    logic [8:0]         w_drop_sum;
    logic [ENTRY_W-1:0] w_head;
    logic [CW-1:0]      w_count;
    upd_entry_t         w_head_s;

    always_comb begin
        w_idle  = (r_state == ST_IDLE);
        w_eff0  = ex0_valid && w_idle && !ext_flush;
        w_br0   = w_eff0 && ex0_flush;
        // An older mispredict makes everything in pipe 1 wrong-path.
        w_eff1  = ex1_valid && w_idle && !ext_flush && !w_br0;
        w_br1   = w_eff1 && ex1_flush;
        w_push0 = w_eff0 && ex0_update_en;
        w_push1 = w_eff1 && ex1_update_en;

        w_cause = CAUSE_NONE;
        if (ext_flush) begin
            w_cause = CAUSE_EXT;
        end else if (w_br0) begin
            w_cause = CAUSE_BR0;
        end else if (w_br1) begin
            w_cause = CAUSE_BR1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sq_cnt_nxt = r_sq_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_cause != CAUSE_NONE) begin
                    w_state_nxt  = ST_SQUASH;
                    w_sq_cnt_nxt = SQ_W'(SQUASH_CYC - 1);
                end
            end
            ST_SQUASH: begin
                if (ext_flush) begin
                    w_sq_cnt_nxt = SQ_W'(SQUASH_CYC - 1);
                end else if (r_sq_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_sq_cnt_nxt = r_sq_cnt - SQ_W'(1);
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_sq_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_sq_cnt         <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_sq_cnt         <= w_sq_cnt_nxt;
            r_redirect_valid <= (w_cause == CAUSE_BR0) || (w_cause == CAUSE_BR1);
            if (w_cause == CAUSE_BR0) begin
                r_redirect_pc <= ex0_target;
            end else if (w_cause == CAUSE_BR1) begin
                r_redirect_pc <= ex1_target;
            end
        end
    end

    bp_update_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_push0     (w_push0),
        .i_data0     (make_entry(ex0_pc, ex0_target, ex0_taken)),
        .i_push1     (w_push1),
        .i_data1     (make_entry(ex1_pc, ex1_target, ex1_taken)),
        .i_pop_ready (upd_ready),
        .o_valid     (upd_valid),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_drop      (w_fifo_drop)
    );

    assign w_drop_sum = {1'b0, r_drop_cnt} + 9'(w_fifo_drop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop_sum > 9'd255) begin
            r_drop_cnt <= 8'd255;
        end else begin
            r_drop_cnt <= w_drop_sum[7:0];
        end
    end

    assign w_head_s       = upd_entry_t'(w_head);
    assign upd_pc         = w_head_s.pc;
    assign upd_target     = w_head_s.target;
    assign upd_taken      = w_head_s.taken;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign squash         = (r_state == ST_SQUASH);
    assign drop_cnt       = r_drop_cnt;
    assign dbg_state      = r_state;

    logic w_unused;
    assign w_unused = ^w_count;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_branch_redirect_ctrl;

    localparam int DEPTH = 4;
    localparam int SC    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex0_valid, ex0_update_en, ex0_flush, ex0_taken;
    logic [31:0] ex0_target, ex0_pc;
    logic        ex1_valid, ex1_update_en, ex1_flush, ex1_taken;
    logic [31:0] ex1_target, ex1_pc;
    logic        ext_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        squash;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc, upd_target;
    logic        upd_taken;
    logic [7:0]  drop_cnt;
    logic        dbg_state;

    branch_redirect_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .SQUASH_CYC (SC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex0_valid      (ex0_valid),
        .ex0_update_en  (ex0_update_en),
        .ex0_flush      (ex0_flush),
        .ex0_taken      (ex0_taken),
        .ex0_target     (ex0_target),
        .ex0_pc         (ex0_pc),
        .ex1_valid      (ex1_valid),
        .ex1_update_en  (ex1_update_en),
        .ex1_flush      (ex1_flush),
        .ex1_taken      (ex1_taken),
        .ex1_target     (ex1_target),
        .ex1_pc         (ex1_pc),
        .ext_flush      (ext_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .squash         (squash),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .drop_cnt       (drop_cnt),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        m_inc[$];
    int          m_drops = 0;
    int          m_sq    = 0;
    logic        m_rv    = 1'b0;
    logic [31:0] m_rpc   = '0;
    bit          m_live  = 0;
    bit          m_pop;
    bit          m_act;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_drops = 0;
            m_sq    = 0;
            m_rv    = 1'b0;
            m_rpc   = '0;
            m_live  = 1;
        end else begin
            m_pop = (exp_q.size() != 0) && upd_ready;
            m_rv  = 1'b0;
            m_act = (m_sq == 0) && !ext_flush;
            m_inc.delete();
            if (ext_flush) begin
                m_sq = SC;
            end else if (m_act && ex0_valid && ex0_flush) begin
                m_rv  = 1'b1;
                m_rpc = ex0_target;
                m_sq  = SC;
                if (ex0_update_en) m_inc.push_back('{ex0_pc, ex0_target, ex0_taken});
            end else begin
                if (m_act && ex0_valid && ex0_update_en) m_inc.push_back('{ex0_pc, ex0_target, ex0_taken});
                if (m_act && ex1_valid && ex1_update_en) m_inc.push_back('{ex1_pc, ex1_target, ex1_taken});
                if (m_act && ex1_valid && ex1_flush) begin
                    m_rv  = 1'b1;
                    m_rpc = ex1_target;
                    m_sq  = SC;
                end else if (m_sq > 0) begin
                    m_sq--;
                end
            end
            if (m_pop) void'(exp_q.pop_front());
            foreach (m_inc[i]) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(m_inc[i]);
                else if (m_drops < 255) m_drops++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_live) begin
            check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
            check("redirect_pc", redirect_pc, m_rpc);
            check("squash", {31'd0, squash}, (m_sq > 0) ? 32'd1 : 32'd0);
            check("upd_valid", {31'd0, upd_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
            check("drop_cnt", {24'd0, drop_cnt}, 32'(m_drops));
            if (exp_q.size() != 0) begin
                check("upd_pc", upd_pc, exp_q[0].pc);
                check("upd_target", upd_target, exp_q[0].target);
                check("upd_taken", {31'd0, upd_taken}, {31'd0, exp_q[0].taken});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_pipes();
        ex0_valid = 0; ex0_update_en = 0; ex0_flush = 0; ex0_taken = 0;
        ex0_target = '0; ex0_pc = '0;
        ex1_valid = 0; ex1_update_en = 0; ex1_flush = 0; ex1_taken = 0;
        ex1_target = '0; ex1_pc = '0;
        ext_flush = 0;
    endtask

    task automatic pipe0(input logic u, input logic f, input logic t,
                         input logic [31:0] tgt, input logic [31:0] pc);
        ex0_valid = 1; ex0_update_en = u; ex0_flush = f; ex0_taken = t;
        ex0_target = tgt; ex0_pc = pc;
    endtask

    task automatic pipe1(input logic u, input logic f, input logic t,
                         input logic [31:0] tgt, input logic [31:0] pc);
        ex1_valid = 1; ex1_update_en = u; ex1_flush = f; ex1_taken = t;
        ex1_target = tgt; ex1_pc = pc;
    endtask

    task automatic dual_update(input logic [31:0] pc_a, input logic [31:0] pc_b);
        pipe0(1, 0, 0, pc_a + 32'd4, pc_a);
        pipe1(1, 0, 1, pc_b + 32'd64, pc_b);
        @(negedge clk);
        clear_pipes();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        clear_pipes();
        upd_ready = 0;
        rst_n     = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_squash", {31'd0, squash}, 32'd0);
        check("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
        check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);

        // Both pipes mispredict: pipe 0 wins, pipe 1 discarded.
        pipe0(1, 1, 1, 32'h1c000100, 32'h1c0000f0);
        pipe1(1, 1, 1, 32'h1c000300, 32'h1c0000f4);
        @(negedge clk);
        clear_pipes();
        check("a_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("a_redirect_pc", redirect_pc, 32'h1c000100);
        check("a_squash_1", {31'd0, squash}, 32'd1);
        check("a_upd_pc", upd_pc, 32'h1c0000f0);
        @(negedge clk);
        check("a_redirect_pulse", {31'd0, redirect_valid}, 32'd0);
        check("a_squash_2", {31'd0, squash}, 32'd1);
        @(negedge clk);
        check("a_squash_end", {31'd0, squash}, 32'd0);
        upd_ready = 1;
        @(negedge clk);
        upd_ready = 0;
        check("a_single_entry", {31'd0, upd_valid}, 32'd0);

        // Pipe 1 mispredicts; pipe 0 update still queued first.
        pipe0(1, 0, 0, 32'h1c0000a4, 32'h1c0000a0);
        pipe1(1, 1, 1, 32'h1c000200, 32'h1c0000b0);
        @(negedge clk);
        clear_pipes();
        check("b_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("b_redirect_pc", redirect_pc, 32'h1c000200);
        check("b_head_pipe0", upd_pc, 32'h1c0000a0);
        check("b_head_taken", {31'd0, upd_taken}, 32'd0);
        upd_ready = 1;
        @(negedge clk);
        upd_ready = 0;
        check("b_second_pc", upd_pc, 32'h1c0000b0);
        check("b_second_target", upd_target, 32'h1c000200);
        check("b_second_taken", {31'd0, upd_taken}, 32'd1);
        @(negedge clk);

        // ext_flush beats ex0_flush; a second ext_flush extends the window.
        ext_flush = 1;
        pipe0(1, 1, 1, 32'h1c000400, 32'h1c000300);
        @(negedge clk);
        clear_pipes();
        ext_flush = 1;
        check("c_no_redirect", {31'd0, redirect_valid}, 32'd0);
        check("c_squash", {31'd0, squash}, 32'd1);
        check("c_fifo_head_kept", upd_pc, 32'h1c0000b0);
        @(negedge clk);
        ext_flush = 0;
        check("c_squash_2", {31'd0, squash}, 32'd1);
        @(negedge clk);
        check("c_squash_extended", {31'd0, squash}, 32'd1);
        @(negedge clk);
        check("c_squash_end", {31'd0, squash}, 32'd0);
        upd_ready = 1;
        @(negedge clk);
        upd_ready = 0;
        check("c_nothing_enqueued", {31'd0, upd_valid}, 32'd0);

        // Overflow: full FIFO without and with a simultaneous pop.
        dual_update(32'h10, 32'h14);
        dual_update(32'h20, 32'h24);
        dual_update(32'h30, 32'h34);
        check("d_drop_two", {24'd0, drop_cnt}, 32'd2);
        upd_ready = 1;
        dual_update(32'h40, 32'h44);
        upd_ready = 0;
        check("d_drop_one", {24'd0, drop_cnt}, 32'd3);
        check("d_head_after_pop", upd_pc, 32'h14);

        // Reset in the middle of a squash window with three entries held.
        upd_ready = 1;
        ext_flush = 1;
        @(negedge clk);
        upd_ready = 0;
        ext_flush = 0;
        check("e_squash_before_rst", {31'd0, squash}, 32'd1);
        check("e_head_before_rst", upd_pc, 32'h20);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check("e_rst_redirect_pc", redirect_pc, 32'd0);
        check("e_rst_squash", {31'd0, squash}, 32'd0);
        check("e_rst_upd_valid", {31'd0, upd_valid}, 32'd0);
        check("e_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        check("e_rst_state", {31'd0, dbg_state}, 32'd0);

        // Saturation: 4 accepted, then 300 drops.
        dual_update(32'h100, 32'h104);
        dual_update(32'h108, 32'h10c);
        for (int i = 0; i < 150; i++) begin
            dual_update(32'h200 + 32'(i) * 8, 32'h204 + 32'(i) * 8);
        end
        check("f_drop_saturated", {24'd0, drop_cnt}, 32'd255);

        // Mixed traffic with varying ready and single/dual pushes.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] pat;
            pat = 4'(i);
            upd_ready = pat[0];
            if (pat[1]) pipe0(1, 0, pat[2], 32'h3000 + 32'(i) * 16, 32'h2000 + 32'(i) * 16);
            if (pat[2] | pat[3]) pipe1(1, 0, pat[3], 32'h5000 + 32'(i) * 16, 32'h4000 + 32'(i) * 16);
            @(negedge clk);
            clear_pipes();
        end
        upd_ready = 1;
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("g_drained", {31'd0, upd_valid}, 32'd0);
        upd_ready = 0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
